hazard3_tick_gen: RTL and testbench

- APB-programmable fractional clock divider that generates the timebase tick for the RISC-V machine timer. It sits directly upstream of that timer.
- Provides a single-cycle `tick` pulse for timers clocked from the same `clk`.
- Provides a toggling `tick_nrz` for timers in another clock domain, which edge-detect it after a synchroniser.
- Average tick period is INT + FRAC/256 `clk` cycles, e.g. 1 µs from a non-integer MHz clock.

---
 rtl/hazard3_tick_gen.sv | 149 ++++++++++++++
 tb/tb_hazard3_tick_gen.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard3_tick_gen.sv
// hazard3_tick_gen: APB-programmable fractional clock divider that produces the
// timebase tick for the RISC-V machine timer. Average tick period is
// INT + FRAC/256 clk cycles. tick is a single-cycle pulse for same-clock timers;
// tick_nrz toggles once per tick for timers in another clock domain.
// Optional feature: define TICK_GEN_DBG_HALT_EN to add a dbg_halt input that
// freezes the count (ctr, acc, tick_nrz) while asserted.
module hazard3_tick_gen #(
    parameter logic [15:0] INT_RESET  = 16'd12,
    parameter logic [7:0]  FRAC_RESET = 8'd0,
    parameter logic        EN_RESET   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
`ifdef TICK_GEN_DBG_HALT_EN
    input  logic        dbg_halt,
`endif
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        tick,
    output logic        tick_nrz
);

    // A zero INT behaves as 1, so the reset count follows the same rule.
    localparam logic [16:0] CTR_RESET = (INT_RESET == 16'd0) ? 17'd1 : {1'b0, INT_RESET};

    logic        en_q, en_d;
    logic [15:0] int_q, int_d;
    logic [7:0]  frac_q, frac_d;
    logic [16:0] ctr_q, ctr_d;
    logic [7:0]  acc_q, acc_d;
    logic        tick_q, tick_d;
    logic        tick_nrz_q, tick_nrz_d;

    logic        bus_access;
    logic        bus_wr;
    logic        sel_ctrl;
    logic        sel_div;
    logic        sel_count;
    logic        halt;
    logic        expire;
    logic [16:0] int_eff;
    logic [16:0] wr_int_eff;
    logic [8:0]  acc_sum;
    logic        unused_pwdata;

    assign bus_access = psel && penable;
    assign bus_wr     = bus_access && pwrite;
    assign sel_ctrl   = (paddr == 16'h0000);
    assign sel_div    = (paddr == 16'h0004);
    assign sel_count  = (paddr == 16'h0008);

    assign pready  = 1'b1;
    assign pslverr = bus_access && !(sel_ctrl || sel_div || sel_count);

    // Only the low 24 write-data bits map onto any register field.
    assign unused_pwdata = ^pwdata[31:24];

`ifdef TICK_GEN_DBG_HALT_EN
    assign halt = dbg_halt;
`else
    assign halt = 1'b0;
`endif

    assign int_eff    = (int_q == 16'd0) ? 17'd1 : {1'b0, int_q};
    assign wr_int_eff = (pwdata[15:0] == 16'd0) ? 17'd1 : {1'b0, pwdata[15:0]};
    assign acc_sum    = {1'b0, acc_q} + {1'b0, frac_q};
    assign expire     = en_q && !halt && (ctr_q <= 17'd1);

    // Read-data mux; unmapped addresses and unused bits read as zero.
    always_comb begin
        prdata = 32'd0;
        if (sel_ctrl) begin
            prdata = {31'd0, en_q};
        end else if (sel_div) begin
            prdata = {8'd0, frac_q, int_q};
        end else if (sel_count) begin
            prdata = {15'd0, ctr_q};
        end
    end

    // Divider next state: count down, reload with INT_EFF plus fractional carry,
    // and let a DIV write restart the count from scratch.
    always_comb begin
        en_d       = en_q;
        int_d      = int_q;
        frac_d     = frac_q;
        ctr_d      = ctr_q;
        acc_d      = acc_q;
        tick_d     = 1'b0;
        tick_nrz_d = tick_nrz_q;

        if (!en_q) begin
            ctr_d = int_eff;
            acc_d = 8'd0;
        end else if (expire) begin
            acc_d      = acc_sum[7:0];
            ctr_d      = int_eff + {16'd0, acc_sum[8]};
            tick_d     = 1'b1;
            tick_nrz_d = ~tick_nrz_q;
        end else if (!halt) begin
            ctr_d = ctr_q - 17'd1;
        end

        if (bus_wr && sel_ctrl) begin
            en_d = pwdata[0];
        end

        // A DIV write wins over a same-cycle expiry: no tick, no toggle.
        if (bus_wr && sel_div) begin
            int_d      = pwdata[15:0];
            frac_d     = pwdata[23:16];
            ctr_d      = wr_int_eff;
            acc_d      = 8'd0;
            tick_d     = 1'b0;
            tick_nrz_d = tick_nrz_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q       <= EN_RESET;
            int_q      <= INT_RESET;
            frac_q     <= FRAC_RESET;
            ctr_q      <= CTR_RESET;
            acc_q      <= 8'd0;
            tick_q     <= 1'b0;
            tick_nrz_q <= 1'b0;
        end else begin
            en_q       <= en_d;
            int_q      <= int_d;
            frac_q     <= frac_d;
            ctr_q      <= ctr_d;
            acc_q      <= acc_d;
            tick_q     <= tick_d;
            tick_nrz_q <= tick_nrz_d;
        end
    end

    assign tick     = tick_q;
    assign tick_nrz = tick_nrz_q;

endmodule

// File: tb/tb_hazard3_tick_gen.sv
// Testbench for hazard3_tick_gen. A tick-schedule model predicts tick, tick_nrz,
// pslverr and read data every cycle; directed tests pin tick times and register
// values to hand-computed constants. Define TICK_GEN_DBG_HALT_EN to include the
// debug-halt test.
module tb_hazard3_tick_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        tick;
    logic        tick_nrz;
    logic        dbg_halt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tick_times[$];

    always #5 clk = ~clk;

    hazard3_tick_gen dut (
        .clk      (clk),
        .rst      (rst),
        .paddr    (paddr),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
`ifdef TICK_GEN_DBG_HALT_EN
        .dbg_halt (dbg_halt),
`endif
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .tick     (tick),
        .tick_nrz (tick_nrz)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- model ----------------
    // Since the last restart (reset, DIV write, or disabled cycle), the k-th tick
    // arrives after k*IE + floor((k-1)*FRAC/256) counting cycles.
    logic        m_en;
    logic [15:0] m_int;
    logic [7:0]  m_frac;
    int          m_nact;
    int          m_k;
    int          m_ticks;
    logic        exp_tick;

    function automatic int ie_of(input logic [15:0] v);
        return (v == 16'd0) ? 1 : int'(v);
    endfunction

    function automatic int off_k(input int k, input int ie, input int f);
        return k * ie + ((k - 1) * f) / 256;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [15:0] a);
        case (a)
            16'h0000: return {31'd0, m_en};
            16'h0004: return {8'd0, m_frac, m_int};
            16'h0008: return m_en ? 32'(off_k(m_k, ie_of(m_int), int'(m_frac)) - m_nact)
                                  : 32'(ie_of(m_int));
            default:  return 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_en     = 1'b1;
            m_int    = 16'd12;
            m_frac   = 8'd0;
            m_nact   = 0;
            m_k      = 1;
            m_ticks  = 0;
            exp_tick = 1'b0;
        end else begin
            exp_tick = 1'b0;
            if (psel && penable && pwrite && paddr == 16'h0004) begin
                m_int  = pwdata[15:0];
                m_frac = pwdata[23:16];
                m_nact = 0;
                m_k    = 1;
            end else if (!m_en) begin
                m_nact = 0;
                m_k    = 1;
            end else if (!dbg_halt) begin
                m_nact++;
                if (m_nact == off_k(m_k, ie_of(m_int), int'(m_frac))) begin
                    exp_tick = 1'b1;
                    m_ticks++;
                    m_k++;
                end
            end
            if (psel && penable && pwrite && paddr == 16'h0000) m_en = pwdata[0];
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Per-cycle compare against the model, plus tick time capture.
    always @(negedge clk) begin
        if (!rst) begin
            check("tick", 32'(tick), 32'(exp_tick));
            check("tick_nrz", 32'(tick_nrz), 32'(m_ticks % 2));
            check("pslverr", 32'(pslverr),
                  32'(psel && penable && !(paddr == 16'h0 || paddr == 16'h4 || paddr == 16'h8)));
            check("pready", 32'(pready), 32'd1);
            if (psel && penable && !pwrite) check("prdata_model", prdata, exp_rd(paddr));
            if (tick) tick_times.push_back(cyc);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apb_wr(input logic [15:0] a, input logic [31:0] d, input logic e);
        paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b1;
        @(negedge clk);
        check("wr_pslverr", 32'(pslverr), 32'(e));
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_rd(input string name, input logic [15:0] a, input logic [31:0] exp,
                          input logic e);
        paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b1;
        @(negedge clk);
        check(name, prdata, exp);
        check({name, "_err"}, 32'(pslverr), 32'(e));
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wait_ticks(input string name, input int n, input int budget);
        int b = 0;
        while (tick_times.size() < n && b < budget) begin
            @(posedge clk);
            #1;
            b++;
        end
        check({name, "_seen"}, 32'(tick_times.size() >= n), 32'd1);
    endtask

    function automatic int tt(input int i);
        return (i < tick_times.size()) ? tick_times[i] : -1;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        int bad;
        int nrz_hold;

        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 16'h0; pwdata = 32'h0; dbg_halt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_nrz", 32'(tick_nrz), 32'd0);
        rst = 1'b0;

        // Reset defaults: INT=12, FRAC=0, EN=1.
        apb_rd("rst_count", 16'h8, 32'd12, 1'b0);
        apb_rd("rst_ctrl", 16'h0, 32'd1, 1'b0);
        apb_rd("rst_div", 16'h4, 32'd12, 1'b0);
        wait_ticks("dflt", 3, 60);
        check("dflt_t0", 32'(tt(0)), 32'd12);
        check("dflt_t1", 32'(tt(1)), 32'd24);
        check("dflt_t2", 32'(tt(2)), 32'd36);
        check("dflt_nrz", 32'(tick_nrz), 32'd1);

        // INT=3: first tick 3 cycles after the first post-write cycle, period 3.
        w = cyc;
        apb_wr(16'h4, 32'h0000_0003, 1'b0);
        tick_times.delete();
        wait_ticks("div3", 101, 400);
        check("div3_first", 32'(tt(0)), 32'(w + 4));
        n = 0; bad = 0;
        foreach (tick_times[i]) begin
            if (tick_times[i] < tt(0) + 300) n++;
            if (i > 0 && tick_times[i] - tick_times[i-1] != 3) bad++;
        end
        check("div3_count300", 32'(n), 32'd100);
        check("div3_spacing", 32'(bad), 32'd0);

        // INT=10, FRAC=0x80: spacing 10, 11, ...; 512 ticks span 5376 cycles.
        w = cyc;
        apb_wr(16'h4, 32'h0080_000A, 1'b0);
        tick_times.delete();
        wait_ticks("frac", 513, 6000);
        check("frac_first", 32'(tt(0)), 32'(w + 11));
        check("frac_gap1", 32'(tt(1) - tt(0)), 32'd10);
        check("frac_gap2", 32'(tt(2) - tt(1)), 32'd11);
        check("frac_512", 32'(tt(512) - tt(0)), 32'd5376);

        // INT=1 and INT=0 both tick every cycle.
        apb_wr(16'h4, 32'h0000_0001, 1'b0);
        tick_times.delete();
        cycles(20);
        check("int1_ticks", 32'(tick_times.size()), 32'd19);
        apb_rd("int1_count", 16'h8, 32'd1, 1'b0);
        apb_wr(16'h4, 32'h0000_0000, 1'b0);
        tick_times.delete();
        cycles(20);
        check("int0_ticks", 32'(tick_times.size()), 32'd19);
        apb_rd("int0_count", 16'h8, 32'd1, 1'b0);
        apb_rd("int0_div", 16'h4, 32'd0, 1'b0);

        // Disable mid-count, reprogram INT=7, re-enable.
        apb_wr(16'h4, 32'd20, 1'b0);
        cycles(5);
        apb_wr(16'h0, 32'd0, 1'b0);
        nrz_hold = m_ticks % 2;
        tick_times.delete();
        cycles(50);
        check("dis_no_ticks", 32'(tick_times.size()), 32'd0);
        apb_wr(16'h4, 32'd7, 1'b0);
        apb_rd("dis_count", 16'h8, 32'd7, 1'b0);
        check("dis_nrz_held", 32'(tick_nrz), 32'(nrz_hold));
        tick_times.delete();
        w = cyc;
        apb_wr(16'h0, 32'd1, 1'b0);
        wait_ticks("reen", 1, 20);
        check("reen_first", 32'(tt(0)), 32'(w + 8));

        // Unmapped accesses error and change nothing; COUNT writes are ignored.
        apb_rd("unmap_rd", 16'hC, 32'd0, 1'b1);
        apb_wr(16'h10, 32'hFFFF_FFFF, 1'b1);
        apb_wr(16'h8, 32'h0000_FFFF, 1'b0);
        apb_rd("after_unmap_div", 16'h4, 32'd7, 1'b0);
        apb_rd("after_unmap_ctrl", 16'h0, 32'd1, 1'b0);

`ifdef TICK_GEN_DBG_HALT_EN
        // Halt at COUNT=5 for 20 cycles; next tick 5 cycles after release.
        tick_times.delete();
        wait_ticks("halt_sync", 1, 20);
        cycles(1);
        dbg_halt = 1'b1;
        tick_times.delete();
        cycles(10);
        apb_rd("halt_count", 16'h8, 32'd5, 1'b0);
        cycles(9);
        check("halt_no_ticks", 32'(tick_times.size()), 32'd0);
        w = cyc;
        dbg_halt = 1'b0;
        wait_ticks("halt_rel", 1, 20);
        check("halt_resume", 32'(tt(0)), 32'(w + 5));
`endif

        // Asynchronous reset while tick is high drops it immediately.
        apb_wr(16'h4, 32'd1, 1'b0);
        cycles(3);
        check("pre_rst_tick", 32'(tick), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_tick", 32'(tick), 32'd0);
        check("async_rst_nrz", 32'(tick_nrz), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick_times.delete();
        wait_ticks("post_rst", 1, 30);
        check("post_rst_first", 32'(tt(0)), 32'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
